// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace-control register block.
package trdb_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_STALL = 2'd2
    } trdb_ctrl_state_e;

    // Register byte offsets
    localparam int unsigned REG_CTRL          = 32'h00;
    localparam int unsigned REG_TRIG_ON_MASK  = 32'h04;
    localparam int unsigned REG_TRIG_OFF_MASK = 32'h08;
    localparam int unsigned REG_STATUS        = 32'h0C;
    localparam int unsigned REG_DROP_CNT      = 32'h10;

    // CTRL bit positions
    localparam int unsigned CTRL_W         = 6;
    localparam int unsigned CTRL_ACT       = 0;
    localparam int unsigned CTRL_NOCONTEXT = 1;
    localparam int unsigned CTRL_NOTIME    = 2;
    localparam int unsigned CTRL_DELTA     = 3;
    localparam int unsigned CTRL_LOSSLESS  = 4;
    localparam int unsigned CTRL_SHALLOW   = 5;
    localparam int unsigned CTRL_SW_ON     = 8;
    localparam int unsigned CTRL_SW_OFF    = 9;
    localparam int unsigned STATUS_CLR     = 31;

    localparam logic [CTRL_W-1:0] CTRL_RST = 6'h0E;

endpackage

// File: rtl/trdb_edge_detect_vec.sv
// Per-bit rising-edge detector; the pulse is combinational against a registered history.
module trdb_edge_detect_vec #(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_sig,
    output logic [W-1:0] o_rise_c
);

    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= '0;
        else       r_prev <= i_sig;
    end

    assign o_rise_c = i_sig & ~r_prev;

endmodule

// File: rtl/trdb_ctrl_regs.sv
// Trace-control register file: maskable on/off triggers, tracing FSM with
// lossless stall mode and a saturating drop counter.
module trdb_ctrl_regs
    import trdb_pkg::*;
#(
    parameter int unsigned N_TRIG = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_req_i,
    input  logic              reg_we_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_ready_o,
    output logic              reg_err_o,
    input  logic [N_TRIG-1:0] trig_on_i,
    input  logic [N_TRIG-1:0] trig_off_i,
    input  logic              encapsulator_ready_i,
    output logic              trace_enable_o,
    output logic              trace_activated_o,
    output logic              stall_o,
    output logic              nocontext_o,
    output logic              notime_o,
    output logic              delta_address_o,
    output logic              lossless_trace_o,
    output logic              shallow_trace_o,
    output logic              encoder_mode_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CTRL_W-1:0] r_ctrl;
    logic [N_TRIG-1:0] r_on_mask, r_off_mask;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_drop_sat;
    logic [31:0]       r_rdata;
    logic              r_ready, r_err;
    logic              r_trace_en, r_stall;
    trdb_ctrl_state_e  r_state, w_state_nxt;

    logic [N_TRIG-1:0] w_on_rise, w_off_rise;
    logic [31:0]       w_rdata;
    logic              w_addr_ok, w_wr, w_hit_ctrl, w_clr;
    logic              w_on_req, w_off_req;
    logic              w_trace_en_nxt, w_stall_nxt, w_drop_inc;
    logic              w_unused_wdata;

    trdb_edge_detect_vec #(.W(N_TRIG)) u_edge_on (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_sig    (trig_on_i),
        .o_rise_c (w_on_rise)
    );

    trdb_edge_detect_vec #(.W(N_TRIG)) u_edge_off (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_sig    (trig_off_i),
        .o_rise_c (w_off_rise)
    );

    assign w_unused_wdata = ^reg_wdata_i;

    // Address decode and read mux; unmapped addresses read as zero
    always_comb begin
        w_addr_ok = 1'b1;
        w_rdata   = '0;
        case (reg_addr_i)
            ADDR_W'(REG_CTRL):          w_rdata = 32'(r_ctrl);
            ADDR_W'(REG_TRIG_ON_MASK):  w_rdata = 32'(r_on_mask);
            ADDR_W'(REG_TRIG_OFF_MASK): w_rdata = 32'(r_off_mask);
            ADDR_W'(REG_STATUS):        w_rdata = {29'd0, r_drop_sat, r_state};
            ADDR_W'(REG_DROP_CNT):      w_rdata = 32'(r_drop_cnt);
            default:                    w_addr_ok = 1'b0;
        endcase
    end

    assign w_wr       = reg_req_i & reg_we_i & w_addr_ok;
    assign w_hit_ctrl = (reg_addr_i == ADDR_W'(REG_CTRL));
    assign w_clr      = w_wr & (reg_addr_i == ADDR_W'(REG_STATUS)) & reg_wdata_i[STATUS_CLR];
    assign w_on_req   = (|(w_on_rise & r_on_mask))
                      | (w_wr & w_hit_ctrl & reg_wdata_i[CTRL_SW_ON]);
    assign w_off_req  = (|(w_off_rise & r_off_mask))
                      | (w_wr & w_hit_ctrl & reg_wdata_i[CTRL_SW_OFF]);

    // Register file, bus response and drop counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl     <= CTRL_RST;
            r_on_mask  <= '0;
            r_off_mask <= '0;
            r_drop_cnt <= '0;
            r_drop_sat <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready <= reg_req_i;
            r_err   <= reg_req_i & ~w_addr_ok;
            r_rdata <= (reg_req_i & ~reg_we_i) ? w_rdata : '0;
            if (w_wr) begin
                case (reg_addr_i)
                    ADDR_W'(REG_CTRL):          r_ctrl     <= reg_wdata_i[CTRL_W-1:0];
                    ADDR_W'(REG_TRIG_ON_MASK):  r_on_mask  <= reg_wdata_i[N_TRIG-1:0];
                    ADDR_W'(REG_TRIG_OFF_MASK): r_off_mask <= reg_wdata_i[N_TRIG-1:0];
                    default: ;
                endcase
            end
            // Clear beats a coincident increment
            if (w_clr) begin
                r_drop_cnt <= '0;
                r_drop_sat <= 1'b0;
            end else if (w_drop_inc) begin
                if (r_drop_cnt != CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                if (r_drop_cnt >= CNT_MAX - CNT_W'(1)) r_drop_sat <= 1'b1;
            end
        end
    end

    // FSM state register plus registered state-derived outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_OFF;
            r_trace_en <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_trace_en <= w_trace_en_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    // Next state: ACT low, then off_req, then ready loss, then on_req
    always_comb begin
        w_state_nxt = r_state;
        if (!r_ctrl[CTRL_ACT]) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (w_on_req && !w_off_req && encapsulator_ready_i) w_state_nxt = ST_ON;
                end
                ST_ON: begin
                    if (w_off_req)                  w_state_nxt = ST_OFF;
                    else if (!encapsulator_ready_i) w_state_nxt = r_ctrl[CTRL_LOSSLESS] ? ST_STALL : ST_OFF;
                end
                ST_STALL: begin
                    if (w_off_req)                 w_state_nxt = ST_OFF;
                    else if (encapsulator_ready_i) w_state_nxt = ST_ON;
                end
                default: w_state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        w_trace_en_nxt = (w_state_nxt != ST_OFF);
        w_stall_nxt    = (w_state_nxt == ST_STALL);
        w_drop_inc     = r_ctrl[CTRL_ACT] && (r_state == ST_ON) && !w_off_req
                      && !encapsulator_ready_i && !r_ctrl[CTRL_LOSSLESS];
    end

    assign reg_rdata_o       = r_rdata;
    assign reg_ready_o       = r_ready;
    assign reg_err_o         = r_err;
    assign trace_enable_o    = r_trace_en;
    assign stall_o           = r_stall;
    assign trace_activated_o = r_ctrl[CTRL_ACT];
    assign nocontext_o       = r_ctrl[CTRL_NOCONTEXT];
    assign notime_o          = r_ctrl[CTRL_NOTIME];
    assign delta_address_o   = r_ctrl[CTRL_DELTA];
    assign lossless_trace_o  = r_ctrl[CTRL_LOSSLESS];
    assign shallow_trace_o   = r_ctrl[CTRL_SHALLOW];
    assign encoder_mode_o    = 1'b0;

endmodule

// File: tb/tb_trdb_ctrl_regs.sv
// Self-checking bench for trdb_ctrl_regs: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_trdb_ctrl_regs;

    localparam int N_TRIG = 4;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              reg_req_i = 1'b0, reg_we_i = 1'b0;
    logic [ADDR_W-1:0] reg_addr_i = '0;
    logic [31:0]       reg_wdata_i = '0;
    logic [31:0]       reg_rdata_o;
    logic              reg_ready_o, reg_err_o;
    logic [N_TRIG-1:0] trig_on_i = '0, trig_off_i = '0;
    logic              encapsulator_ready_i = 1'b1;
    logic              trace_enable_o, trace_activated_o, stall_o;
    logic              nocontext_o, notime_o, delta_address_o;
    logic              lossless_trace_o, shallow_trace_o, encoder_mode_o;

    int n_pass = 0;
    int n_total = 0;

    trdb_ctrl_regs #(.N_TRIG(N_TRIG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o),
        .reg_ready_o(reg_ready_o), .reg_err_o(reg_err_o),
        .trig_on_i(trig_on_i), .trig_off_i(trig_off_i),
        .encapsulator_ready_i(encapsulator_ready_i),
        .trace_enable_o(trace_enable_o), .trace_activated_o(trace_activated_o),
        .stall_o(stall_o), .nocontext_o(nocontext_o), .notime_o(notime_o),
        .delta_address_o(delta_address_o), .lossless_trace_o(lossless_trace_o),
        .shallow_trace_o(shallow_trace_o), .encoder_mode_o(encoder_mode_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: state 0=OFF 1=ON 2=STALL
    int          m_ctrl, m_on_mask, m_off_mask, m_state, m_cnt;
    bit          m_sat, m_ready, m_err, m_te, m_stall;
    int          m_rdata;
    logic [3:0]  m_prev_on, m_prev_off;

    always @(posedge clk_i or posedge rst_i) begin
        bit wr, onr, offr, act, rdy, mapped, drop, clr;
        int nxt, rv, a;
        if (rst_i) begin
            m_ctrl = 32'h0E; m_on_mask = 0; m_off_mask = 0; m_state = 0; m_cnt = 0;
            m_sat = 0; m_ready = 0; m_err = 0; m_te = 0; m_stall = 0; m_rdata = 0;
            m_prev_on = 0; m_prev_off = 0;
        end else begin
            a = int'(reg_addr_i);
            mapped = (a == 0 || a == 4 || a == 8 || a == 12 || a == 16);
            wr   = reg_req_i && reg_we_i && mapped;
            onr  = ((trig_on_i & ~m_prev_on & 4'(m_on_mask)) != 0) || (wr && a == 0 && reg_wdata_i[8]);
            offr = ((trig_off_i & ~m_prev_off & 4'(m_off_mask)) != 0) || (wr && a == 0 && reg_wdata_i[9]);
            act  = m_ctrl[0];
            rdy  = encapsulator_ready_i;
            if (!act) nxt = 0;
            else if (m_state == 0) nxt = (onr && !offr && rdy) ? 1 : 0;
            else if (offr) nxt = 0;
            else if (m_state == 1) nxt = rdy ? 1 : (m_ctrl[4] ? 2 : 0);
            else nxt = rdy ? 1 : 2;
            drop = act && m_state == 1 && !offr && !rdy && !m_ctrl[4];
            case (a)
                0: rv = m_ctrl;
                4: rv = m_on_mask;
                8: rv = m_off_mask;
                12: rv = (int'(m_sat) << 2) | m_state;
                16: rv = m_cnt;
                default: rv = 0;
            endcase
            clr = wr && a == 12 && reg_wdata_i[31];
            if (wr && a == 0) m_ctrl = int'(reg_wdata_i & 32'h3F);
            if (wr && a == 4) m_on_mask = int'(reg_wdata_i & 32'hF);
            if (wr && a == 8) m_off_mask = int'(reg_wdata_i & 32'hF);
            if (clr) begin
                m_cnt = 0; m_sat = 0;
            end else if (drop) begin
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (m_cnt == CMAX) m_sat = 1;
            end
            m_ready = reg_req_i;
            m_err   = reg_req_i && !mapped;
            m_rdata = (reg_req_i && !reg_we_i) ? rv : 0;
            m_state = nxt;
            m_te    = (nxt != 0);
            m_stall = (nxt == 2);
            m_prev_on  = trig_on_i;
            m_prev_off = trig_off_i;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        chk("trace_enable", 32'(trace_enable_o), 32'(m_te));
        chk("stall", 32'(stall_o), 32'(m_stall));
        chk("ready", 32'(reg_ready_o), 32'(m_ready));
        chk("err", 32'(reg_err_o), 32'(m_err));
        if (m_ready) chk("rdata", reg_rdata_o, 32'(m_rdata));
        chk("options", {26'd0, shallow_trace_o, lossless_trace_o, delta_address_o,
                        notime_o, nocontext_o, trace_activated_o}, 32'(m_ctrl));
        chk("encoder_mode", 32'(encoder_mode_o), 32'd0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus(input bit we, input int addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = ADDR_W'(addr); reg_wdata_i = wd;
        cyc(1);
        reg_req_i = 1'b0; reg_we_i = 1'b0;
        rd = reg_rdata_o; er = reg_err_o;
    endtask

    task automatic rd_chk(input string name, input int addr, input logic [31:0] exp);
        logic [31:0] rd; logic er;
        bus(1'b0, addr, 32'd0, rd, er);
        chk(name, rd, exp);
    endtask

    task automatic wr(input int addr, input logic [31:0] wd);
        logic [31:0] rd; logic er;
        bus(1'b1, addr, wd, rd, er);
    endtask

    initial begin
        logic [31:0] rd; logic er;
        cyc(3);
        rst_i = 1'b0;
        cyc(1);
        chk("rst_trace_enable", 32'(trace_enable_o), 32'd0);
        chk("rst_nocontext", 32'(nocontext_o), 32'd1);
        rd_chk("rst_ctrl", 0, 32'h0E);
        rd_chk("rst_on_mask", 4, 32'h0);
        rd_chk("rst_drop_cnt", 16, 32'h0);

        // Masked trigger ignored, unmasked one turns tracing on
        wr(0, 32'h01);
        wr(4, 32'h2);
        trig_on_i = 4'h1; cyc(2);
        chk("masked_trig_off", 32'(trace_enable_o), 32'd0);
        trig_on_i = 4'h3; cyc(1);
        chk("trig_on", 32'(trace_enable_o), 32'd1);
        rd_chk("status_on", 12, 32'h1);

        // off trigger beats a simultaneous SW_ON
        wr(8, 32'h1);
        trig_off_i = 4'h1;
        reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = '0; reg_wdata_i = 32'h101;
        cyc(1);
        reg_req_i = 1'b0; reg_we_i = 1'b0; trig_off_i = 4'h0;
        chk("off_beats_on", 32'(trace_enable_o), 32'd0);

        // Ready loss without lossless drops the trace
        trig_on_i = 4'h0; cyc(1);
        trig_on_i = 4'h3; cyc(1);
        chk("retrigger_on", 32'(trace_enable_o), 32'd1);
        encapsulator_ready_i = 1'b0; cyc(1);
        encapsulator_ready_i = 1'b1;
        chk("drop_off", 32'(trace_enable_o), 32'd0);
        rd_chk("drop_cnt_1", 16, 32'd1);

        // Lossless: stall, then resume
        wr(0, 32'h11);
        wr(0, 32'h111);
        chk("sw_on", 32'(trace_enable_o), 32'd1);
        encapsulator_ready_i = 1'b0; cyc(1);
        chk("stall_enter", 32'(stall_o), 32'd1);
        cyc(1);
        chk("stall_hold", 32'(stall_o), 32'd1);
        chk("stall_te", 32'(trace_enable_o), 32'd1);
        encapsulator_ready_i = 1'b1; cyc(1);
        chk("stall_exit", 32'(stall_o), 32'd0);
        chk("stall_exit_te", 32'(trace_enable_o), 32'd1);
        rd_chk("drop_cnt_kept", 16, 32'd1);

        // Saturation: four more drops on top of one
        wr(0, 32'h01);
        for (int i = 0; i < 4; i++) begin
            wr(0, 32'h101);
            encapsulator_ready_i = 1'b0; cyc(1);
            encapsulator_ready_i = 1'b1;
        end
        rd_chk("drop_cnt_sat", 16, 32'd3);
        rd_chk("status_sat", 12, 32'h4);
        wr(12, 32'h8000_0000);
        rd_chk("drop_cnt_clr", 16, 32'd0);
        rd_chk("status_clr", 12, 32'h0);

        // Unmapped address and RO write
        bus(1'b0, 20, 32'd0, rd, er);
        chk("unmapped_err", 32'(er), 32'd1);
        chk("unmapped_rdata", rd, 32'd0);
        wr(16, 32'hFFFF_FFFF);
        rd_chk("ro_write_ignored", 16, 32'd0);

        // Reset while stalled
        wr(0, 32'h11);
        wr(0, 32'h111);
        encapsulator_ready_i = 1'b0; cyc(1);
        chk("pre_rst_stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1; #2;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_te", 32'(trace_enable_o), 32'd0);
        cyc(2);
        rst_i = 1'b0; encapsulator_ready_i = 1'b1;
        cyc(1);
        rd_chk("rst_ctrl_again", 0, 32'h0E);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int pick;
            trig_on_i  = trig_on_i  ^ 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            trig_off_i = trig_off_i ^ 4'($urandom_range(0, 7) == 0 ? $urandom : 0);
            encapsulator_ready_i = ($urandom_range(0, 7) != 0);
            reg_req_i = ($urandom_range(0, 2) == 0);
            reg_we_i  = $urandom_range(0, 1) == 1;
            pick = $urandom_range(0, 7);
            reg_addr_i  = (pick < 6) ? ADDR_W'(pick * 4) : ADDR_W'($urandom);
            reg_wdata_i = $urandom;
            if (reg_addr_i == '0) begin
                reg_wdata_i[0] = ($urandom_range(0, 7) != 0);
                reg_wdata_i[9] = ($urandom_range(0, 3) == 0);
            end
            cyc(1);
        end
        reg_req_i = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trdb_ctrl_regs.md
Name: trdb_ctrl_regs

Overview:
- Parametrised trace-control block with a memory-mapped register file that sets the encoder options and the tracing state.
- Generalises the fixed on/off controller with N_TRIG maskable trigger channels, software on/off requests and a lossless stall mode.
- Adds a saturating drop counter.
- Sits between the trigger unit, the filter, the encapsulator and the packet emitter.

Parameters:
N_TRIG, 4, number of trigger input channels (1..16)
ADDR_W, 5, register byte-address width
CNT_W, 16, drop-counter width (1..32)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
reg_req_i  in  1  register access request
reg_we_i  in  1  1 = write, 0 = read
reg_addr_i  in  ADDR_W  byte address, word aligned
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data, valid with reg_ready_o
reg_ready_o  out  1  access completion pulse
reg_err_o  out  1  bad address, valid with reg_ready_o
trig_on_i  in  N_TRIG  turn-on trigger levels
trig_off_i  in  N_TRIG  turn-off trigger levels (filter plus trigger unit)
encapsulator_ready_i  in  1  encapsulator can accept packets
trace_enable_o  out  1  tracing currently enabled
trace_activated_o  out  1  CTRL.ACT
stall_o  out  1  request to stall the core (lossless mode only)
nocontext_o, notime_o, delta_address_o, lossless_trace_o, shallow_trace_o  out  1 each  option bits
encoder_mode_o  out  1  constant 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, with these exceptions.
  - nocontext_o, notime_o and delta_address_o reset to 1.
  - Every register resets to 0, except CTRL, which resets to 0x0E.
- Register map (addresses are byte addresses):
  - 0x00 CTRL RW. Bit 0 ACT, bit 1 NOCONTEXT, bit 2 NOTIME, bit 3 DELTA, bit 4 LOSSLESS, bit 5 SHALLOW.
  - CTRL bit 8 SW_ON and bit 9 SW_OFF are write-1 pulses; both read 0.
  - 0x04 TRIG_ON_MASK RW. Bits [N_TRIG-1:0] are used; upper bits read 0.
  - 0x08 TRIG_OFF_MASK RW, same layout as TRIG_ON_MASK.
  - 0x0C STATUS. Bits [1:0] hold the state code (RO); bit 2 holds DROP_SAT (RO).
  - Writing STATUS with bit 31 = 1 clears DROP_CNT and DROP_SAT.
  - 0x10 DROP_CNT RO, zero-extended to 32 bits.
- Bus timing:
  - reg_ready_o pulses 1 cycle after a sampled reg_req_i; the write takes effect at that edge.
  - Back-to-back requests are allowed, one per cycle.
  - An unmapped address sets reg_err_o=1 alongside reg_ready_o; the read returns 0 and a write has no effect.
  - A write to an RO register is ignored with no error.
- Triggers: each channel has a rising-edge detector (registered previous sample).
  - on_req = |(trig_on rising & TRIG_ON_MASK) or SW_ON pulse.
  - off_req = |(trig_off rising & TRIG_OFF_MASK) or SW_OFF pulse.
- FSM (state codes: OFF=0, ON=1, STALL=2):
  - OFF to ON when on_req, ACT=1, !off_req and encapsulator_ready_i=1. on_req while ready=0 is dropped, not queued.
  - ON to OFF when off_req.
  - ON when encapsulator_ready_i=0 and no off_req: with LOSSLESS=1 go to STALL; with LOSSLESS=0 go to OFF and increment DROP_CNT.
  - STALL to ON when ready=1 and no off_req. STALL to OFF on off_req, which has priority.
  - ACT cleared: any state goes to OFF on the next edge.
  - Priority order: off_req beats ready loss, which beats on_req.
- Output timing:
  - trace_enable_o = 1 in ON and STALL. It is registered, so it changes on the edge where the triggering condition is sampled.
  - stall_o = 1 only in STALL.
- DROP_CNT saturates at 2^CNT_W-1; hitting the limit sets DROP_SAT.
  - A clear and an increment in the same cycle: clear wins, and the count becomes 0.
- Option outputs are driven directly from the CTRL register bits. encoder_mode_o is tied to 0.
- Reset mid-operation: immediate return to OFF with all registers at their reset values; the edge-detector history resets to 0.

Decomposition:
- trdb_pkg gets:
  - trdb_ctrl_state_e (OFF, ON, STALL)
  - register offset localparams
  - CTRL bit-index constants
  - CTRL_RST = 0x0E
- Sub-module: trdb_edge_detect_vec, a parametrised-width rising-edge detector with asynchronous active-high reset. It is instantiated twice.

Test Plan:
- Reset, then read CTRL, 0x04 and 0x10 → reads return 0x0E, 0 and 0; trace_enable_o=0; nocontext_o=1.
- Write CTRL=0x01 and TRIG_ON_MASK=0x2, hold ready=1.
  - Raise trig_on_i=0x1 → stays OFF.
  - Raise trig_on_i=0x3 → trace_enable_o=1 on the next edge; STATUS[1:0]=1.
- While ON with TRIG_OFF_MASK=0x1, pulse trig_off_i[0] together with an SW_ON write → OFF; trace_enable_o drops on the next edge.
- ON with LOSSLESS=0, drop encapsulator_ready_i for 1 cycle → OFF; DROP_CNT=1.
  - Repeat with LOSSLESS=1 → STALL with stall_o=1; return to ON once ready=1; DROP_CNT unchanged.
- CNT_W=2: force 4 drops → DROP_CNT=3 and DROP_SAT=1. Write STATUS=0x8000_0000 → both read 0.
- Read 0x14 → reg_err_o=1 with reg_rdata_o=0. Assert rst_i while in STALL → OFF; stall_o=0; CTRL=0x0E.
